// File: rtl/uart_rx_os6.sv
// 8N1 UART receiver, LSB first, sampling rxd on a 6x-baud clk_en tick.
// Each bit is decided by a 2-of-3 vote over oversample ticks 2, 3 and 4.
module uart_rx_os6 #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_vld,
    output logic       rx_ferr,
    output logic       rx_busy
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] START   = 3'd1;
    localparam logic [2:0] DATA    = 3'd2;
    localparam logic [2:0] STOP    = 3'd3;
    localparam logic [2:0] WAIT_HI = 3'd4;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [2:0] state_q, state_d;
    logic [2:0] os_cnt_q, os_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       samp2_q, samp2_d;
    logic       samp3_q, samp3_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_vld_q, rx_vld_d;
    logic       rx_ferr_q, rx_ferr_d;
    logic       rxd_s;
    logic       vote;

    // The synchronizer runs every clk; only the receiver proper is tick-gated.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], rxd};
    assign rxd_s  = sync_q[SYNC_STAGES-1];

    // Third vote input is the live sample taken on the os_cnt=4 tick itself.
    assign vote = (samp2_q & samp3_q) | (samp2_q & rxd_s) | (samp3_q & rxd_s);

    always_comb begin
        state_d   = state_q;
        os_cnt_d  = os_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        samp2_d   = samp2_q;
        samp3_d   = samp3_q;
        rx_data_d = rx_data_q;
        rx_vld_d  = 1'b0;
        rx_ferr_d = 1'b0;

        if (clk_en) begin
            if (os_cnt_q == 3'd2) samp2_d = rxd_s;
            if (os_cnt_q == 3'd3) samp3_d = rxd_s;

            case (state_q)
                IDLE: begin
                    if (!rxd_s) begin
                        state_d  = START;
                        os_cnt_d = 3'd1;
                    end
                end
                START: begin
                    if (os_cnt_q == 3'd4 && vote) begin
                        state_d  = IDLE;
                        os_cnt_d = 3'd0;
                    end else if (os_cnt_q == 3'd5) begin
                        state_d   = DATA;
                        os_cnt_d  = 3'd0;
                        bit_cnt_d = 3'd0;
                    end else begin
                        os_cnt_d = os_cnt_q + 3'd1;
                    end
                end
                DATA: begin
                    if (os_cnt_q == 3'd4) shift_d = {vote, shift_q[7:1]};
                    if (os_cnt_q == 3'd5) begin
                        os_cnt_d  = 3'd0;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_d = STOP;
                    end else begin
                        os_cnt_d = os_cnt_q + 3'd1;
                    end
                end
                STOP: begin
                    // Decided one tick early so the next start edge can be caught promptly.
                    if (os_cnt_q == 3'd4) begin
                        os_cnt_d = 3'd0;
                        if (vote) begin
                            rx_data_d = shift_q;
                            rx_vld_d  = 1'b1;
                            state_d   = IDLE;
                        end else begin
                            rx_ferr_d = 1'b1;
                            state_d   = WAIT_HI;
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + 3'd1;
                    end
                end
                WAIT_HI: begin
                    if (rxd_s) state_d = IDLE;
                end
                default: begin
                    state_d  = IDLE;
                    os_cnt_d = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '1;
            state_q   <= IDLE;
            os_cnt_q  <= 3'd0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            samp2_q   <= 1'b0;
            samp3_q   <= 1'b0;
            rx_data_q <= 8'h00;
            rx_vld_q  <= 1'b0;
            rx_ferr_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            os_cnt_q  <= os_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            samp2_q   <= samp2_d;
            samp3_q   <= samp3_d;
            rx_data_q <= rx_data_d;
            rx_vld_q  <= rx_vld_d;
            rx_ferr_q <= rx_ferr_d;
        end
    end

    assign rx_data = rx_data_q;
    assign rx_vld  = rx_vld_q;
    assign rx_ferr = rx_ferr_q;
    assign rx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_os6.sv
// Directed plus randomized frames for uart_rx_os6, checked against a frame-level
// model: a frame with a high stop bit yields its byte, a low stop bit yields one error.
module tb_uart_rx_os6;

    logic       clk;
    logic       rst_n;
    logic       clk_en;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_vld;
    logic       rx_ferr;
    logic       rx_busy;

    int tests = 0;
    int fails = 0;
    int tick_div = 12;
    int tick_cnt = 0;

    int         vld_cnt = 0;
    int         ferr_cnt = 0;
    int         vld_wide = 0;
    int         ferr_wide = 0;
    logic       prev_vld = 1'b0;
    logic       prev_ferr = 1'b0;
    logic       busy_seen = 1'b0;
    logic       busy_at_vld = 1'b1;
    logic [7:0] got_q[$];

    int         exp_vld = 0;
    int         exp_ferr = 0;
    logic [7:0] exp_data = 8'h00;
    logic [7:0] exp_q[$];

    uart_rx_os6 #(.SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clk_en  (clk_en),
        .rxd     (rxd),
        .rx_data (rx_data),
        .rx_vld  (rx_vld),
        .rx_ferr (rx_ferr),
        .rx_busy (rx_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Oversample tick: one clk high every tick_div clocks (every clock when tick_div is 1).
    initial begin
        clk_en = 1'b0;
        forever begin
            @(negedge clk);
            if (tick_cnt >= tick_div - 1) begin
                clk_en = 1'b1;
                tick_cnt = 0;
            end else begin
                clk_en = 1'b0;
                tick_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (rx_busy) busy_seen = 1'b1;
        if (rx_vld) begin
            vld_cnt++;
            got_q.push_back(rx_data);
            busy_at_vld = rx_busy;
            if (prev_vld) vld_wide++;
        end
        if (rx_ferr) begin
            ferr_cnt++;
            if (prev_ferr) ferr_wide++;
        end
        prev_vld = rx_vld;
        prev_ferr = rx_ferr;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drives the first nbits of a frame; pct scales the line bit time against six ticks.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input int pct, input int nbits);
        logic [9:0] frame;
        int period100;
        int n;
        frame = {stop_bit, data, 1'b0};
        period100 = tick_div * 6 * pct;
        n = 0;
        for (int k = 0; k < nbits; k++) begin
            rxd = frame[k];
            while (n * 100 < (k + 1) * period100) begin
                @(negedge clk);
                n++;
            end
        end
    endtask

    task automatic modelFrame(input logic [7:0] data, input logic stop_bit);
        if (stop_bit) begin
            exp_vld++;
            exp_data = data;
            exp_q.push_back(data);
        end else begin
            exp_ferr++;
        end
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic waitIdle(input string tag);
        int i;
        i = 0;
        while (rx_busy && i < tick_div * 6 * 12 + 20) begin
            @(negedge clk);
            i++;
        end
        checkOutput(tag, rx_busy, 1'b0);
        waitCycles(3);
    endtask

    task automatic checkFrames(input string tag);
        logic [7:0] e;
        logic [7:0] g;
        checkOutput({tag, "_vld_cnt"}, vld_cnt, exp_vld);
        checkOutput({tag, "_ferr_cnt"}, ferr_cnt, exp_ferr);
        checkOutput({tag, "_rx_data"}, rx_data, exp_data);
        checkOutput({tag, "_vld_wide"}, vld_wide, 0);
        checkOutput({tag, "_ferr_wide"}, ferr_wide, 0);
        checkOutput({tag, "_qsize"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            checkOutput({tag, "_byte"}, g, e);
        end
        got_q.delete();
    endtask

    task automatic randomPhase();
        waitCycles($urandom_range(0, tick_div * 6));
    endtask

    initial begin
        logic [7:0] d;
        logic       s;
        int         pct;

        rst_n = 1'b0;
        rxd = 1'b1;
        waitCycles(5);
        checkOutput("rst_rx_data", rx_data, 8'h00);
        checkOutput("rst_rx_vld", rx_vld, 1'b0);
        checkOutput("rst_rx_ferr", rx_ferr, 1'b0);
        checkOutput("rst_rx_busy", rx_busy, 1'b0);
        rst_n = 1'b1;
        waitCycles(40);

        busy_seen = 1'b0;
        applyStimulus(8'hA5, 1'b1, 100, 10);
        modelFrame(8'hA5, 1'b1);
        waitIdle("a5_idle");
        checkFrames("a5");
        checkOutput("a5_busy_seen", busy_seen, 1'b1);
        checkOutput("a5_busy_at_vld", busy_at_vld, 1'b0);

        randomPhase();
        applyStimulus(8'h00, 1'b1, 100, 10);
        modelFrame(8'h00, 1'b1);
        applyStimulus(8'hFF, 1'b1, 100, 10);
        modelFrame(8'hFF, 1'b1);
        waitIdle("b2b_idle");
        checkFrames("b2b");

        randomPhase();
        busy_seen = 1'b0;
        rxd = 1'b0;
        waitCycles(2 * tick_div);
        rxd = 1'b1;
        waitCycles(10 * tick_div);
        waitIdle("glitch_idle");
        checkOutput("glitch_busy_seen", busy_seen, 1'b1);
        checkFrames("glitch");

        randomPhase();
        applyStimulus(8'h3C, 1'b0, 100, 10);
        modelFrame(8'h3C, 1'b0);
        rxd = 1'b0;
        waitCycles(20 * 6 * tick_div);
        checkOutput("break_busy_held", rx_busy, 1'b1);
        checkFrames("break");
        rxd = 1'b1;
        waitIdle("break_release_idle");
        randomPhase();
        applyStimulus(8'h81, 1'b1, 100, 10);
        modelFrame(8'h81, 1'b1);
        waitIdle("x81_idle");
        checkFrames("x81");

        randomPhase();
        applyStimulus(8'h55, 1'b1, 100, 5);
        rxd = 1'b1;
        waitCycles(3 * tick_div);
        checkOutput("midrst_busy_before", rx_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_rx_data", rx_data, 8'h00);
        checkOutput("midrst_rx_vld", rx_vld, 1'b0);
        checkOutput("midrst_rx_ferr", rx_ferr, 1'b0);
        checkOutput("midrst_rx_busy", rx_busy, 1'b0);
        exp_data = 8'h00;
        waitCycles(3);
        rst_n = 1'b1;
        waitCycles(12 * tick_div);
        checkFrames("midrst");
        applyStimulus(8'h12, 1'b1, 100, 10);
        modelFrame(8'h12, 1'b1);
        waitIdle("x12_idle");
        checkFrames("x12");

        randomPhase();
        applyStimulus(8'h96, 1'b1, 97, 10);
        modelFrame(8'h96, 1'b1);
        waitIdle("fast_idle");
        checkFrames("fast");
        randomPhase();
        applyStimulus(8'h96, 1'b1, 103, 10);
        modelFrame(8'h96, 1'b1);
        waitIdle("slow_idle");
        checkFrames("slow");

        tick_div = 1;
        waitCycles(20);
        d = 8'($urandom);
        applyStimulus(d, 1'b1, 100, 10);
        modelFrame(d, 1'b1);
        waitIdle("cont_vld_idle");
        checkFrames("cont_vld");
        applyStimulus(8'h6B, 1'b0, 100, 10);
        modelFrame(8'h6B, 1'b0);
        rxd = 1'b1;
        waitIdle("cont_ferr_idle");
        checkFrames("cont_ferr");
        tick_div = 12;
        waitCycles(40);

        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            s = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 2))
                0: pct = 97;
                1: pct = 100;
                default: pct = 103;
            endcase
            randomPhase();
            applyStimulus(d, s, pct, 10);
            modelFrame(d, s);
            rxd = 1'b1;
            waitIdle("rand_idle");
            checkFrames("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
